// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
// Optional feature macro: MULTICYCLE_CTRL_TRAP_EN adds the TRAP state.
package ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned IMM_W   = 3;
    localparam int unsigned WB_W    = 2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
`ifdef MULTICYCLE_CTRL_TRAP_EN
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
`else
        S_WB     = 3'd4
`endif
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;

    localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SLL   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_SLT   = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SLTU  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR   = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SRL   = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_OR    = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_AND   = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SRA   = 4'b1101;

    localparam logic [IMM_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_W-1:0] IMM_J = 3'd4;

    localparam logic [WB_W-1:0] WB_ALU = 2'b00;
    localparam logic [WB_W-1:0] WB_MEM = 2'b01;
    localparam logic [WB_W-1:0] WB_PC4 = 2'b10;

    // True for every opcode the core implements (FENCE included)
    function automatic logic is_legal(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI,
            OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_FENCE: is_legal = 1'b1;
            default:                                  is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic             funct7b5,
    output logic [ALU_W-1:0] alu_sel_c
);

    // funct3 maps straight onto the low ALU bits; bit 3 picks SUB/SRA variants
    always_comb begin
        alu_sel_c = ALU_ADD;
        case (opcode)
            OPC_OP:     alu_sel_c = {funct7b5 && (funct3 == 3'b000 || funct3 == 3'b101), funct3};
            OPC_OP_IMM: alu_sel_c = {funct7b5 && (funct3 == 3'b101), funct3};
            OPC_LUI:    alu_sel_c = ALU_PASSB;
            default:    alu_sel_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port. Outputs are combinational from state, instruction and handshake
// inputs. Optional macro MULTICYCLE_CTRL_TRAP_EN halts on illegal opcodes.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               mem_ready,
    input  logic               branch_taken,
    output logic               MemReq,
    output logic               MemRW,
    output logic               MemAddrSel,
    output logic               IRWrite,
    output logic               PCEn,
    output logic               PCSel,
    output logic               RegWEn,
    output logic               Asel,
    output logic               Bsel,
    output logic [IMM_W-1:0]   ImmSel,
    output logic [ALU_W-1:0]   ALUSel,
    output logic [WB_W-1:0]    WBSel,
    output logic               retire,
    output logic               trap
);

    state_t             state_q, state_d;
    logic [OPC_W-1:0]   opcode;
    logic [ALU_W-1:0]   ex_alu_c;
    logic               ex_asel_c, ex_bsel_c;
    logic [IMM_W-1:0]   ex_imm_c;
    logic               unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    alu_decoder u_alu_decoder (
        .opcode    (opcode),
        .funct3    (instruction[14:12]),
        .funct7b5  (instruction[30]),
        .alu_sel_c (ex_alu_c)
    );

    // Operand and immediate selects used while the ALU result must be valid
    always_comb begin
        ex_asel_c = 1'b0;
        ex_bsel_c = 1'b1;
        ex_imm_c  = IMM_I;
        case (opcode)
            OPC_OP:     ex_bsel_c = 1'b0;
            OPC_STORE:  ex_imm_c  = IMM_S;
            OPC_BRANCH: begin ex_asel_c = 1'b1; ex_imm_c = IMM_B; end
            OPC_AUIPC:  begin ex_asel_c = 1'b1; ex_imm_c = IMM_U; end
            OPC_LUI:    ex_imm_c = IMM_U;
            OPC_JAL:    begin ex_asel_c = 1'b1; ex_imm_c = IMM_J; end
            default:    ;
        endcase
    end

    // State register; reset forces FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state and control outputs; all outputs forced low while in reset
    always_comb begin
        state_d    = state_q;
        MemReq     = 1'b0;
        MemRW      = 1'b0;
        MemAddrSel = 1'b0;
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        PCSel      = 1'b0;
        RegWEn     = 1'b0;
        Asel       = 1'b0;
        Bsel       = 1'b0;
        ImmSel     = IMM_I;
        ALUSel     = ALU_ADD;
        WBSel      = WB_ALU;
        retire     = 1'b0;
        trap       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemReq = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OPC_FENCE) begin
                        PCEn    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (!is_legal(opcode)) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                        state_d = S_TRAP;
`else
                        PCEn    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
`endif
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    Asel   = ex_asel_c;
                    Bsel   = ex_bsel_c;
                    ImmSel = ex_imm_c;
                    ALUSel = ex_alu_c;
                    if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                        state_d = S_MEM;
                    end else if (opcode == OPC_BRANCH) begin
                        PCEn    = 1'b1;
                        PCSel   = branch_taken;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    Asel       = ex_asel_c;
                    Bsel       = ex_bsel_c;
                    ImmSel     = ex_imm_c;
                    ALUSel     = ex_alu_c;
                    MemReq     = 1'b1;
                    MemAddrSel = 1'b1;
                    MemRW      = (opcode == OPC_STORE);
                    if (mem_ready) begin
                        if (opcode == OPC_STORE) begin
                            PCEn    = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    RegWEn  = 1'b1;
                    PCEn    = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    if (opcode == OPC_LOAD) begin
                        WBSel = WB_MEM;
                    end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
                        WBSel = WB_PC4;
                        PCSel = 1'b1;
                    end
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                S_TRAP: begin
                    trap = 1'b1;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule
